keypad_scan4x4: RTL

Matrix-keypad scanner for the board's 4x4 hex keypad, the input-side counterpart of the multiplexed 7-segment display driver.
- Drives one column low at a time and samples the rows.
- Debounces over whole scans.
- Emits a one-cycle key_valid strobe with a 4-bit key code.
- Sits beside the CPU core on the 50 MHz board clock and feeds hex entry (ROM/RAM poke, test input) into the 4004 system.

---
 rtl/keypad_pkg.sv | 14 +
 rtl/keypad_scan4x4_if.sv | 13 +
 rtl/keypad_col_scanner.sv | 46 ++++
 rtl/keypad_scan4x4.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and column-drive helper for the 4x4 keypad scanner
package keypad_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} keyState_e;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} scanClass_e;

    // Active-low one-cold column drive for a column index.
    function automatic logic [NUM_COLS-1:0] colDrive(input logic [1:0] idx);
        return ~(NUM_COLS'(1) << idx);
    endfunction
endpackage

// File: rtl/keypad_scan4x4_if.sv
// rtl/keypad_scan4x4_if.sv - keypad pins and key-event outputs of the scanner
interface keypad_scan4x4_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] row_n;
    logic [NUM_COLS-1:0] col_n;
    logic [CODE_W-1:0]   key_code;
    logic                key_valid;
    logic                key_held;

    modport master (input row_n, output col_n, output key_code, output key_valid, output key_held);
    modport slave  (output row_n, input col_n, input key_code, input key_valid, input key_held);
endinterface

// File: rtl/keypad_col_scanner.sv
// rtl/keypad_col_scanner.sv - row synchronizer, column dwell/rotation and per-scan snapshot
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [NUM_ROWS-1:0]          rowN,
    output logic [NUM_COLS-1:0]          colN,
    output logic [NUM_ROWS*NUM_COLS-1:0] snapshot,
    output logic                         scanDone
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [NUM_ROWS-1:0] rowSync1, rowSync2;
    logic [DW-1:0]       dwellCnt;
    logic [1:0]          colIdx;

    // SCAN_DIV >= 4 keeps the 2-flop delay inside the dwell, so the sample sees the driven column.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rowSync1 <= 4'hF;
            rowSync2 <= 4'hF;
            dwellCnt <= '0;
            colIdx   <= 2'd0;
            colN     <= colDrive(2'd0);
            snapshot <= '0;
            scanDone <= 1'b0;
        end else begin
            rowSync1 <= rowN;
            rowSync2 <= rowSync1;
            scanDone <= 1'b0;
            if (dwellCnt == DIV_LAST) begin
                dwellCnt                       <= '0;
                snapshot[{colIdx, 2'b00} +: 4] <= ~rowSync2;
                colIdx                         <= colIdx + 2'd1;
                colN                           <= colDrive(colIdx + 2'd1);
                scanDone                       <= (colIdx == 2'd3);
            end else begin
                dwellCnt <= dwellCnt + DW'(1);
            end
        end
    end
endmodule

// File: rtl/keypad_scan4x4.sv
// rtl/keypad_scan4x4.sv - 4x4 keypad scanner with scan-level debounce; KEYPAD_TYPEMATIC_EN adds auto-repeat
module keypad_scan4x4
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_TYPEMATIC_EN
    ,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
`endif
) (
    input  logic clk,
    input  logic nrst,
    keypad_scan4x4_if.master kp
);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam bit DEB_ONE = (DEBOUNCE_SCANS == 1);

    logic [NUM_ROWS*NUM_COLS-1:0] snapshot, keyVec;
    logic                         scanDone;
    scanClass_e                   scanClass;
    logic [CODE_W-1:0]            candCode, cand, keyCode;
    keyState_e                    state;
    logic [CNT_W-1:0]             debCnt;
    logic                         keyValid, keyHeld;

`ifdef KEYPAD_TYPEMATIC_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_DELAY + REPEAT_RATE);
    logic [REP_W-1:0] repCnt, repNext;
    assign repNext = repCnt + REP_W'(1);
`endif

    keypad_col_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
        .clk      (clk),
        .nrst     (nrst),
        .rowN     (kp.row_n),
        .colN     (kp.col_n),
        .snapshot (snapshot),
        .scanDone (scanDone)
    );

    // Snapshot is column-major; reorder so the bit index equals the key code row*4+col.
    always_comb begin
        keyVec   = '0;
        candCode = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLS; c++)
                keyVec[r*NUM_COLS + c] = snapshot[c*NUM_ROWS + r];
        for (int i = 0; i < NUM_ROWS*NUM_COLS; i++)
            if (keyVec[i]) candCode = CODE_W'(i);
        scanClass = MULTI;
        if ($countones(keyVec) == 0)      scanClass = NONE;
        else if ($countones(keyVec) == 1) scanClass = SINGLE;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            cand     <= '0;
            debCnt   <= '0;
            keyCode  <= '0;
            keyValid <= 1'b0;
            keyHeld  <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
            repCnt   <= '0;
`endif
        end else begin
            keyValid <= 1'b0;
            if (scanDone) begin
                unique case (state)
                    IDLE: if (scanClass == SINGLE) begin
                        cand <= candCode;
                        if (DEB_ONE) begin
                            keyCode  <= candCode;
                            keyValid <= 1'b1;
                            keyHeld  <= 1'b1;
                            debCnt   <= '0;
                            state    <= PRESSED;
`ifdef KEYPAD_TYPEMATIC_EN
                            repCnt   <= '0;
`endif
                        end else begin
                            debCnt <= CNT_W'(1);
                            state  <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: if (scanClass != SINGLE) begin
                        debCnt <= '0;
                        state  <= IDLE;
                    end else if (candCode != cand) begin
                        cand   <= candCode;
                        debCnt <= CNT_W'(1);
                    end else if (debCnt >= DEB_LAST) begin
                        keyCode  <= cand;
                        keyValid <= 1'b1;
                        keyHeld  <= 1'b1;
                        debCnt   <= '0;
                        state    <= PRESSED;
`ifdef KEYPAD_TYPEMATIC_EN
                        repCnt   <= '0;
`endif
                    end else begin
                        debCnt <= debCnt + CNT_W'(1);
                    end
                    // A different single key while held is ignored until a clean release.
                    PRESSED: if (scanClass == NONE) begin
                        if (DEB_ONE) begin
                            debCnt  <= '0;
                            keyHeld <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            debCnt <= CNT_W'(1);
                            state  <= RELEASE;
                        end
                    end else begin
                        debCnt <= '0;
`ifdef KEYPAD_TYPEMATIC_EN
                        if (scanClass == MULTI) begin
                            repCnt <= '0;
                        end else if (repNext == REP_FIRST) begin
                            repCnt   <= repNext;
                            keyValid <= 1'b1;
                        end else if (repNext == REP_NEXT) begin
                            repCnt   <= REP_FIRST;
                            keyValid <= 1'b1;
                        end else begin
                            repCnt <= repNext;
                        end
`endif
                    end
                    RELEASE: if (scanClass != NONE) begin
                        debCnt <= '0;
                        state  <= PRESSED;
                    end else if (debCnt >= DEB_LAST) begin
                        debCnt  <= '0;
                        keyHeld <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        debCnt <= debCnt + CNT_W'(1);
                    end
                endcase
            end
        end
    end

    assign kp.key_code  = keyCode;
    assign kp.key_valid = keyValid;
    assign kp.key_held  = keyHeld;
endmodule
